// File: rtl/flip_pkg.sv
// flip_pkg: shared types and helpers for the flip commit engine.
package flip_pkg;

   localparam int N_ACCUM_DEF = 16;
   localparam int WORD_W_DEF  = 8;
   localparam int N_WORDS     = N_ACCUM_DEF / WORD_W_DEF;
   localparam int PC_W        = 64;

   typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

   function automatic logic [6:0] popcount(input logic [PC_W-1:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < PC_W; i++) c = c + 7'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/flip_commit_if.sv
// flip_commit_if: valid/ready read-modify-write memory port.
interface flip_commit_if #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 8
);

   logic [ADDR_W-1:0] mem_addr_out;
   logic              mem_rd_out;
   logic              mem_wr_out;
   logic [WORD_W-1:0] mem_wdata_out;
   logic              mem_ready_in;
   logic [WORD_W-1:0] mem_rdata_in;
   logic              mem_rvalid_in;

   modport master (
      output mem_addr_out, mem_rd_out, mem_wr_out, mem_wdata_out,
      input  mem_ready_in, mem_rdata_in, mem_rvalid_in
   );

   modport slave (
      input  mem_addr_out, mem_rd_out, mem_wr_out, mem_wdata_out,
      output mem_ready_in, mem_rdata_in, mem_rvalid_in
   );

endinterface

// File: rtl/flip_word_select.sv
// flip_word_select: picks the lowest memory word holding any pending flip.
module flip_word_select
   import flip_pkg::*;
#(
   parameter int N_ACCUM = N_ACCUM_DEF,
   parameter int WORD_W  = WORD_W_DEF,
   parameter int IDX_W   = 1
) (
   input  logic [N_ACCUM-1:0] pending,
   output logic [IDX_W-1:0]   idx,
   output logic [WORD_W-1:0]  mask,
   output logic               any
);

   localparam int NW = N_ACCUM / WORD_W;

   // Scan downwards so the lowest nonzero word is the last to assign.
   always_comb begin
      idx  = '0;
      mask = '0;
      for (int i = NW - 1; i >= 0; i--)
         if (|pending[i*WORD_W +: WORD_W]) begin
            idx  = IDX_W'(i);
            mask = pending[i*WORD_W +: WORD_W];
         end
      any = |pending;
   end

endmodule

// File: rtl/flip_commit.sv
// flip_commit: merges accumulator triggers into pending flips and commits
// them to weight memory one word at a time via read-modify-write.
module flip_commit
   import flip_pkg::*;
#(
   parameter int N_ACCUM   = N_ACCUM_DEF,
   parameter int WORD_W    = WORD_W_DEF,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               prop_in,
   input  logic [N_ACCUM-1:0] trig_in,
   flip_commit_if.master      mem,
   output logic               idle_out,
   output logic [CNT_W-1:0]   flips_out
);

   localparam int NW    = N_ACCUM / WORD_W;
   localparam int IDX_W = NW > 1 ? $clog2(NW) : 1;
   localparam int CW1   = CNT_W + 1;

   state_t             state_q, state_d;
   logic [N_ACCUM-1:0] pending_q, pending_d, sample, clr;
   logic [IDX_W-1:0]   idx_q, idx_d, sel_idx;
   logic [WORD_W-1:0]  mask_q, mask_d, sel_mask, rdata_q, rdata_d;
   logic [CNT_W-1:0]   flips_q, flips_d;
   logic [CNT_W:0]     flips_sum;
   logic               idle_q, idle_d, sel_any;

   flip_word_select #(.N_ACCUM(N_ACCUM), .WORD_W(WORD_W), .IDX_W(IDX_W)) u_sel (
      .pending(pending_q),
      .idx    (sel_idx),
      .mask   (sel_mask),
      .any    (sel_any)
   );

   assign sample    = prop_in ? trig_in : '0;
   assign clr       = N_ACCUM'(sel_mask) << (int'(sel_idx) * WORD_W);
   assign flips_sum = {1'b0, flips_q} + CW1'(popcount(PC_W'(mask_q)));

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q ^ sample;
      idx_d     = idx_q;
      mask_d    = mask_q;
      rdata_d   = rdata_q;
      flips_d   = flips_q;
      case (state_q)
         IDLE: if (sel_any) begin
            state_d   = RD_REQ;
            idx_d     = sel_idx;
            mask_d    = sel_mask;
            pending_d = (pending_q & ~clr) ^ sample;
         end
         RD_REQ: if (mem.mem_ready_in) state_d = RD_WAIT;
         RD_WAIT: if (mem.mem_rvalid_in) begin
            rdata_d = mem.mem_rdata_in;
            state_d = WR_REQ;
         end
         WR_REQ: if (mem.mem_ready_in) begin
            state_d = IDLE;
            flips_d = flips_sum[CNT_W] ? '1 : flips_sum[CNT_W-1:0];
         end
         default: state_d = IDLE;
      endcase
      idle_d = (state_q == IDLE) && (pending_q == '0);
   end

   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         state_q   <= IDLE;
         pending_q <= '0;
         idx_q     <= '0;
         mask_q    <= '0;
         rdata_q   <= '0;
         flips_q   <= '0;
         idle_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         idx_q     <= idx_d;
         mask_q    <= mask_d;
         rdata_q   <= rdata_d;
         flips_q   <= flips_d;
         idle_q    <= idle_d;
      end

   // Address and data are forced to zero outside the request states.
   assign mem.mem_rd_out    = state_q == RD_REQ;
   assign mem.mem_wr_out    = state_q == WR_REQ;
   assign mem.mem_addr_out  = (state_q == RD_REQ || state_q == WR_REQ) ? ADDR_W'(BASE_ADDR + int'(idx_q)) : '0;
   assign mem.mem_wdata_out = state_q == WR_REQ ? rdata_q ^ mask_q : '0;
   assign idle_out          = idle_q;
   assign flips_out         = flips_q;

endmodule

// File: tb/tb_flip_commit.sv
// tb_flip_commit: directed and randomized checks of flip_commit against a
// behavioural memory and a net-parity reference model.
module tb_flip_commit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prop = 1'b0;
   logic [15:0] trig = '0;
   logic        idle;
   logic [15:0] flips;

   flip_commit_if #(.ADDR_W(8), .WORD_W(8)) mem_if ();

   flip_commit #(
      .N_ACCUM(16), .WORD_W(8), .BASE_ADDR(16), .ADDR_W(8), .CNT_W(16)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .prop_in  (prop),
      .trig_in  (trig),
      .mem      (mem_if.master),
      .idle_out (idle),
      .flips_out(flips)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails = 0;

   logic [7:0] mem [256];
   int   stall_cfg = 0;
   bit   rand_stall = 0;
   bit   spurious = 0;
   int   n_rd = 0;
   int   n_wr = 0;
   int   tally = 0;
   logic [7:0] wlog_a[$];
   logic [7:0] wlog_d[$];

   // Behavioural memory: answers one cycle after each accepted read.
   initial begin
      bit rd_acc, wr_acc;
      int stall_left;
      logic [7:0] acc_addr, acc_data;
      rd_acc = 0; wr_acc = 0; stall_left = 0; acc_addr = '0; acc_data = '0;
      mem_if.mem_ready_in = 1'b1;
      mem_if.mem_rvalid_in = 1'b0;
      mem_if.mem_rdata_in = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            rd_acc = 0; wr_acc = 0; stall_left = stall_cfg;
            mem_if.mem_ready_in = 1'b1;
            mem_if.mem_rvalid_in = 1'b0;
         end else begin
            if (rd_acc) begin
               mem_if.mem_rvalid_in = 1'b1;
               mem_if.mem_rdata_in = mem[acc_addr];
               n_rd++;
            end else begin
               mem_if.mem_rvalid_in = spurious && ($urandom_range(0, 2) == 0);
               mem_if.mem_rdata_in = 8'($urandom);
            end
            if (wr_acc) begin
               tally += $countones(mem[acc_addr] ^ acc_data);
               mem[acc_addr] = acc_data;
               wlog_a.push_back(acc_addr);
               wlog_d.push_back(acc_data);
               n_wr++;
            end
            rd_acc = 0; wr_acc = 0;
            checks++;
            if (mem_if.mem_rd_out && mem_if.mem_wr_out) begin
               fails++;
               $display("FAIL rd_wr_exclusive: rd=%b wr=%b, required not both high", mem_if.mem_rd_out, mem_if.mem_wr_out);
            end
            if (mem_if.mem_rd_out || mem_if.mem_wr_out) begin
               if (stall_left > 0) begin
                  mem_if.mem_ready_in = 1'b0;
                  stall_left--;
               end else begin
                  mem_if.mem_ready_in = 1'b1;
                  rd_acc = mem_if.mem_rd_out;
                  wr_acc = mem_if.mem_wr_out;
                  acc_addr = mem_if.mem_addr_out;
                  acc_data = mem_if.mem_wdata_out;
                  stall_left = rand_stall ? int'($urandom_range(0, 3)) : stall_cfg;
               end
            end else mem_if.mem_ready_in = 1'b1;
         end
      end
   end

   task automatic do_reset();
      prop = 1'b0;
      trig = '0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         if (idle) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, mem_if.mem_wdata_out, idle, flips} !== {2'b00, 8'h00, 8'h00, 1'b1, 16'h0}) begin
         fails++;
         $display("FAIL reset_during: rd=%b wr=%b addr=%h wdata=%h idle=%b flips=%0d, required 0 0 00 00 1 0",
                  mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, mem_if.mem_wdata_out, idle, flips);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, mem_if.mem_wdata_out, idle, flips} !== {2'b00, 8'h00, 8'h00, 1'b1, 16'h0}) begin
         fails++;
         $display("FAIL reset_after: rd=%b wr=%b addr=%h wdata=%h idle=%b flips=%0d, required 0 0 00 00 1 0",
                  mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, mem_if.mem_wdata_out, idle, flips);
      end
   endtask

   task automatic test_single();
      int w0;
      do_reset();
      mem[8'h10] = 8'h00;
      w0 = n_wr;
      prop = 1'b1; trig = 16'h0008;
      @(negedge clk);
      prop = 1'b0; trig = '0;
      checks++;
      if (mem_if.mem_rd_out !== 1'b0) begin
         fails++; $display("FAIL single_t0_rd: got %b want 0", mem_if.mem_rd_out);
      end
      @(negedge clk);
      checks++;
      if ({mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, idle} !== {2'b10, 8'h10, 1'b0}) begin
         fails++; $display("FAIL single_rdreq: rd=%b wr=%b addr=%h idle=%b, want 1 0 10 0", mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, idle);
      end
      @(negedge clk);
      checks++;
      if ({mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_rvalid_in} !== 3'b001) begin
         fails++; $display("FAIL single_rdwait: rd=%b wr=%b rvalid=%b, want 0 0 1", mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_rvalid_in);
      end
      @(negedge clk);
      checks++;
      if ({mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, mem_if.mem_wdata_out} !== {2'b01, 8'h10, 8'h08}) begin
         fails++; $display("FAIL single_wrreq: rd=%b wr=%b addr=%h wdata=%h, want 0 1 10 08", mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, mem_if.mem_wdata_out);
      end
      @(negedge clk);
      checks++;
      if ({flips, mem[8'h10]} !== {16'd1, 8'h08}) begin
         fails++; $display("FAIL single_commit: flips=%0d mem=%h, want 1 08", flips, mem[8'h10]);
      end
      @(negedge clk);
      checks++;
      if ({idle, 32'(n_wr - w0)} !== {1'b1, 32'd1}) begin
         fails++; $display("FAIL single_idle: idle=%b writes=%0d, want 1 1", idle, n_wr - w0);
      end
   endtask

   task automatic test_multi_word();
      int w0;
      bit ok;
      do_reset();
      mem[8'h10] = 8'hFF; mem[8'h11] = 8'h00;
      w0 = wlog_a.size();
      prop = 1'b1; trig = 16'h1022;
      @(negedge clk);
      prop = 1'b0; trig = '0;
      wait_idle(ok);
      checks++;
      if (!ok) begin
         fails++; $display("FAIL multi_timeout: idle=%b want 1", idle);
      end
      checks++;
      if (wlog_a.size() - w0 != 2) begin
         fails++; $display("FAIL multi_count: writes=%0d want 2", wlog_a.size() - w0);
      end else begin
         checks++;
         if ({wlog_a[w0], wlog_d[w0], wlog_a[w0+1], wlog_d[w0+1]} !== {8'h10, 8'hDD, 8'h11, 8'h10}) begin
            fails++; $display("FAIL multi_order: got %h<-%h %h<-%h want 10<-dd 11<-10", wlog_a[w0], wlog_d[w0], wlog_a[w0+1], wlog_d[w0+1]);
         end
      end
      checks++;
      if (flips !== 16'd3) begin
         fails++; $display("FAIL multi_flips: got %0d want 3", flips);
      end
   endtask

   task automatic test_cancel();
      int w0;
      bit ok;
      stall_cfg = 5;
      do_reset();
      mem[8'h10] = 8'h55; mem[8'h11] = 8'h00;
      w0 = wlog_a.size();
      prop = 1'b1; trig = 16'h0200;
      @(negedge clk);
      prop = 1'b0; trig = '0;
      @(negedge clk);
      prop = 1'b1; trig = 16'h0004;
      @(negedge clk);
      @(negedge clk);
      prop = 1'b0; trig = '0;
      wait_idle(ok);
      stall_cfg = 0;
      checks++;
      if (!ok) begin
         fails++; $display("FAIL cancel_timeout: idle=%b want 1", idle);
      end
      checks++;
      if (wlog_a.size() - w0 != 1) begin
         fails++; $display("FAIL cancel_count: writes=%0d want 1", wlog_a.size() - w0);
      end else begin
         checks++;
         if ({wlog_a[w0], wlog_d[w0]} !== {8'h11, 8'h02}) begin
            fails++; $display("FAIL cancel_write: got %h<-%h want 11<-02", wlog_a[w0], wlog_d[w0]);
         end
      end
      checks++;
      if ({mem[8'h10], flips} !== {8'h55, 16'd1}) begin
         fails++; $display("FAIL cancel_result: mem10=%h flips=%0d want 55 1", mem[8'h10], flips);
      end
   endtask

   task automatic test_inflight();
      int w0;
      bit ok;
      do_reset();
      mem[8'h10] = 8'hA0;
      w0 = wlog_a.size();
      prop = 1'b1; trig = 16'h0001;
      @(negedge clk);
      prop = 1'b0; trig = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_rvalid_in} !== 3'b001) begin
         fails++; $display("FAIL inflight_rdwait: rd=%b wr=%b rvalid=%b want 0 0 1", mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_rvalid_in);
      end
      prop = 1'b1; trig = 16'h0010;
      @(negedge clk);
      prop = 1'b0; trig = '0;
      wait_idle(ok);
      checks++;
      if (!ok) begin
         fails++; $display("FAIL inflight_timeout: idle=%b want 1", idle);
      end
      checks++;
      if (wlog_a.size() - w0 != 2) begin
         fails++; $display("FAIL inflight_count: writes=%0d want 2", wlog_a.size() - w0);
      end else begin
         checks++;
         if ({wlog_a[w0], wlog_d[w0], wlog_a[w0+1], wlog_d[w0+1]} !== {8'h10, 8'hA1, 8'h10, 8'hB1}) begin
            fails++; $display("FAIL inflight_writes: got %h<-%h %h<-%h want 10<-a1 10<-b1", wlog_a[w0], wlog_d[w0], wlog_a[w0+1], wlog_d[w0+1]);
         end
      end
      checks++;
      if (flips !== 16'd2) begin
         fails++; $display("FAIL inflight_flips: got %0d want 2", flips);
      end
   endtask

   task automatic test_stall();
      int r0, w0, rd_cyc, wr_cyc, hold_err;
      stall_cfg = 5;
      do_reset();
      mem[8'h10] = 8'h3C;
      r0 = n_rd; w0 = n_wr; rd_cyc = 0; wr_cyc = 0; hold_err = 0;
      prop = 1'b1; trig = 16'h0080;
      @(negedge clk);
      prop = 1'b0; trig = '0;
      for (int i = 0; i < 40; i++) begin
         if (mem_if.mem_rd_out) begin
            rd_cyc++;
            if (mem_if.mem_addr_out !== 8'h10) hold_err++;
         end
         if (mem_if.mem_wr_out) begin
            wr_cyc++;
            if ({mem_if.mem_addr_out, mem_if.mem_wdata_out} !== {8'h10, 8'hBC}) hold_err++;
         end
         @(negedge clk);
      end
      stall_cfg = 0;
      checks++;
      if ({rd_cyc, wr_cyc, hold_err} !== {32'd6, 32'd6, 32'd0}) begin
         fails++; $display("FAIL stall_hold: rd_cycles=%0d wr_cycles=%0d unstable=%0d want 6 6 0", rd_cyc, wr_cyc, hold_err);
      end
      checks++;
      if ({32'(n_rd - r0), 32'(n_wr - w0), mem[8'h10], flips, idle} !== {32'd1, 32'd1, 8'hBC, 16'd1, 1'b1}) begin
         fails++; $display("FAIL stall_result: reads=%0d writes=%0d mem=%h flips=%0d idle=%b want 1 1 bc 1 1",
                           n_rd - r0, n_wr - w0, mem[8'h10], flips, idle);
      end
   endtask

   task automatic test_async_reset();
      int w0, rd_seen;
      bit ok;
      do_reset();
      mem[8'h10] = 8'h00; mem[8'h11] = 8'h77;
      prop = 1'b1; trig = 16'h0002;
      @(negedge clk);
      prop = 1'b0; trig = '0;
      wait_idle(ok);
      checks++;
      if (!ok || flips !== 16'd1) begin
         fails++; $display("FAIL areset_pre: idle=%b flips=%0d want 1 1", idle, flips);
      end
      w0 = n_wr;
      prop = 1'b1; trig = 16'h0401;
      @(negedge clk);
      prop = 1'b0; trig = '0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, mem_if.mem_wdata_out, idle, flips} !== {2'b00, 8'h00, 8'h00, 1'b1, 16'h0}) begin
         fails++; $display("FAIL areset_outputs: rd=%b wr=%b addr=%h wdata=%h idle=%b flips=%0d want 0 0 00 00 1 0",
                           mem_if.mem_rd_out, mem_if.mem_wr_out, mem_if.mem_addr_out, mem_if.mem_wdata_out, idle, flips);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_if.mem_rd_out || mem_if.mem_wr_out) rd_seen++;
      end
      checks++;
      if ({32'(n_wr - w0), 32'(rd_seen), mem[8'h10], mem[8'h11], idle, flips} !== {32'd0, 32'd0, 8'h02, 8'h77, 1'b1, 16'h0}) begin
         fails++; $display("FAIL areset_after: writes=%0d req_cycles=%0d mem10=%h mem11=%h idle=%b flips=%0d want 0 0 02 77 1 0",
                           n_wr - w0, rd_seen, mem[8'h10], mem[8'h11], idle, flips);
      end
   endtask

   // Reference: final memory equals initial XOR the parity of all sampled triggers.
   task automatic test_random();
      logic [7:0]  init0, init1;
      logic [15:0] net;
      int w0, t0, bad_addr;
      bit ok;
      for (int r = 0; r < 3; r++) begin
         do_reset();
         rand_stall = 1; spurious = 1;
         init0 = 8'($urandom); init1 = 8'($urandom);
         mem[8'h10] = init0; mem[8'h11] = init1;
         net = '0; w0 = wlog_a.size(); t0 = tally; bad_addr = 0;
         for (int c = 0; c < 300; c++) begin
            prop = 1'($urandom_range(0, 1));
            trig = 16'($urandom & $urandom & $urandom);
            if (prop) net ^= trig;
            @(negedge clk);
         end
         prop = 1'b0; trig = '0;
         wait_idle(ok);
         rand_stall = 0; spurious = 0;
         for (int i = w0; i < wlog_a.size(); i++)
            if (wlog_a[i] != 8'h10 && wlog_a[i] != 8'h11) bad_addr++;
         checks++;
         if (!ok) begin
            fails++; $display("FAIL rand_timeout: round %0d idle=%b want 1", r, idle);
         end
         checks++;
         if ({mem[8'h10], mem[8'h11]} !== {init0 ^ net[7:0], init1 ^ net[15:8]}) begin
            fails++; $display("FAIL rand_memory: round %0d got %h %h want %h %h", r, mem[8'h10], mem[8'h11], init0 ^ net[7:0], init1 ^ net[15:8]);
         end
         checks++;
         if (32'(flips) !== 32'(tally - t0)) begin
            fails++; $display("FAIL rand_flips: round %0d got %0d want %0d", r, flips, tally - t0);
         end
         checks++;
         if (bad_addr != 0) begin
            fails++; $display("FAIL rand_addr: round %0d stray writes=%0d want 0", r, bad_addr);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset();
      test_single();
      test_multi_word();
      test_cancel();
      test_inflight();
      test_stall();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
